// File: rtl/period_stepper.sv
// period_stepper: octave-step period register driven by held push buttons.
// One step is taken on press, a second after a hold delay, then steps auto-repeat.
// Doubling and halving are bound-checked without overflow.
// Also drives an LED level bar and a square-wave tone at the current period.
module period_stepper #(
  parameter int WIDTH         = 24,
  parameter int LED_W         = 10,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init_period,
  input  logic [WIDTH-1:0] max_period,
  input  logic [WIDTH-1:0] min_period,
  input  logic             load,
  input  logic             increase,
  input  logic             decrease,
  output logic [WIDTH-1:0] period,
  output logic [LED_W-1:0] led,
  output logic             tone_out,
  output logic             at_max,
  output logic             at_min
);

  localparam int LVL_W   = $clog2(LED_W + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(LED_W / 2);
  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(LED_W);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t           state;
  logic             dir;      // 1: increase held, 0: decrease held
  logic [CNT_W-1:0] hcnt;
  logic [LVL_W-1:0] lvl;
  logic [WIDTH-1:0] tcnt;

  logic [WIDTH-1:0] half;
  logic             dbl_ok, hlv_ok;
  logic             attempt, up, held, step_ok, reinit;

  // Bound checks: doubling is compared at WIDTH+1 bits so a carried-out MSB is caught
  assign half   = period >> 1;
  assign dbl_ok = {period, 1'b0} <= {1'b0, max_period};
  assign hlv_ok = (half >= min_period) && (half != '0);
  assign at_max = ~dbl_ok;
  assign at_min = ~hlv_ok;

  // Thermometer bar: top lvl bits lit
  assign led = ~({LED_W{1'b1}} >> lvl);

  assign reinit = load || (state == S_LOAD);
  assign held   = (dir ? increase : decrease) && !(increase && decrease);

  // Decide whether this edge attempts a step, and in which direction
  always_comb begin
    attempt = 1'b0;
    up      = dir;
    case (state)
      S_IDLE: begin
        attempt = increase ^ decrease;
        up      = increase;
      end
      S_HOLD:   attempt = held && (hcnt == HOLD_END);
      S_REPEAT: attempt = held && (hcnt == REP_END);
      default:  attempt = 1'b0;
    endcase
    step_ok = attempt && !reinit && (up ? dbl_ok : hlv_ok);
  end

  // Press FSM with period and level registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_LOAD;
      period <= '0;
      lvl    <= LVL_RST;
      dir    <= 1'b0;
      hcnt   <= '0;
    end else if (reinit) begin
      period <= init_period;
      lvl    <= LVL_RST;
      hcnt   <= '0;
      state  <= S_IDLE;
    end else begin
      if (step_ok) begin
        if (up) begin
          period <= period << 1;
          lvl    <= (lvl == '0) ? '0 : lvl - LVL_W'(1);
        end else begin
          period <= half;
          lvl    <= (lvl == LVL_TOP) ? LVL_TOP : lvl + LVL_W'(1);
        end
      end
      case (state)
        S_IDLE: begin
          if (increase ^ decrease) begin
            dir   <= increase;
            hcnt  <= '0;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!held) begin
            state <= S_IDLE;
          end else if (hcnt == HOLD_END) begin
            hcnt  <= '0;
            state <= S_REPEAT;
          end else begin
            hcnt <= hcnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!held)               state <= S_IDLE;
          else if (hcnt == REP_END) hcnt <= '0;
          else                      hcnt <= hcnt + CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tone: each phase lasts period cycles; a period change restarts the phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt     <= '0;
      tone_out <= 1'b0;
    end else if (period == '0) begin
      tcnt     <= '0;
      tone_out <= 1'b0;
    end else if (reinit || step_ok) begin
      tcnt <= '0;
    end else if (tcnt == period - WIDTH'(1)) begin
      tcnt     <= '0;
      tone_out <= ~tone_out;
    end else begin
      tcnt <= tcnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_period_stepper.sv
// Scoreboard bench for period_stepper: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_period_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] init_period, max_period, min_period;
  logic       load, increase, decrease;
  logic [7:0] period;
  logic [9:0] led;
  logic       tone_out, at_max, at_min;

  period_stepper #(.WIDTH(8), .LED_W(10), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .init_period(init_period), .max_period(max_period),
    .min_period(min_period), .load(load), .increase(increase), .decrease(decrease),
    .period(period), .led(led), .tone_out(tone_out), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] per;
    logic [9:0] led;
    logic       amax, amin, tone, tchk;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic [7:0] p, input logic [9:0] l,
                           input logic amx, input logic amn);
    exp_t e;
    e.name = nm; e.per = p; e.led = l; e.amax = amx; e.amin = amn; e.tone = 1'b0; e.tchk = 1'b0;
    q.push_back(e);
  endtask

  task automatic expect_tone(input string nm, input logic [7:0] p, input logic t);
    exp_t e;
    e.name = nm; e.per = p; e.led = 10'b1111100000; e.amax = 1'b0; e.amin = 1'b0;
    e.tone = t; e.tchk = 1'b1;
    q.push_back(e);
  endtask

  // Monitor: outputs are stable at the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tot_cnt++;
      if (e.tchk) begin
        if (tone_out === e.tone && period === e.per) pass_cnt++;
        else $display("FAIL %s: got period=%0d tone=%b, want period=%0d tone=%b",
                      e.name, period, tone_out, e.per, e.tone);
      end else begin
        if (period === e.per && led === e.led && at_max === e.amax && at_min === e.amin)
          pass_cnt++;
        else
          $display("FAIL %s: got period=%0d led=%b at_max=%b at_min=%b, want period=%0d led=%b at_max=%b at_min=%b",
                   e.name, period, led, at_max, at_min, e.per, e.led, e.amax, e.amin);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt + 1);
    $finish;
  end

  initial begin
    reset = 1'b0; load = 1'b0; increase = 1'b0; decrease = 1'b0;
    init_period = 8'd16; max_period = 8'd128; min_period = 8'd2;
    #12;
    expect_st("reset", 8'd0, 10'b1111100000, 1'b0, 1'b1);
    tone_out_chk_reset: expect_tone("reset_tone", 8'd0, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);
    expect_st("load16", 8'd16, 10'b1111100000, 1'b0, 1'b0);
    tick(15); expect_tone("tone_lo_end", 8'd16, 1'b0);
    tick(1);  expect_tone("tone_rise",   8'd16, 1'b1);
    tick(15); expect_tone("tone_hi_end", 8'd16, 1'b1);
    tick(1);  expect_tone("tone_fall",   8'd16, 1'b0);

    // single pulse, then re-press
    increase = 1'b1; tick(1); increase = 1'b0;
    expect_st("pulse32", 8'd32, 10'b1111000000, 1'b0, 1'b0);
    tick(5);
    expect_st("no_more", 8'd32, 10'b1111000000, 1'b0, 1'b0);
    increase = 1'b1; tick(1); increase = 1'b0;
    expect_st("repress64", 8'd64, 10'b1110000000, 1'b0, 1'b0);
    tick(2);

    load = 1'b1; tick(1); load = 1'b0;
    expect_st("reload16", 8'd16, 10'b1111100000, 1'b0, 1'b0);

    // hold increase: steps at cycles 0, 4, 6; cycle 8 rejected
    increase = 1'b1;
    tick(1); expect_st("hold_c0", 8'd32, 10'b1111000000, 1'b0, 1'b0);
    tick(3); expect_st("hold_c3", 8'd32, 10'b1111000000, 1'b0, 1'b0);
    tick(1); expect_st("hold_c4", 8'd64, 10'b1110000000, 1'b0, 1'b0);
    tick(2); expect_st("rep_c6", 8'd128, 10'b1100000000, 1'b1, 1'b0);
    tick(2); expect_st("rep_c8", 8'd128, 10'b1100000000, 1'b1, 1'b0);

    // async reset mid-REPEAT, checked before the next rising edge
    tick(1);
    #2 reset = 1'b0;
    #1 expect_st("async_rst", 8'd0, 10'b1111100000, 1'b0, 1'b1);
    expect_tone("async_tone", 8'd0, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1); expect_st("rel_load", 8'd16, 10'b1111100000, 1'b0, 1'b0);
    tick(1); expect_st("rel_step", 8'd32, 10'b1111000000, 1'b0, 1'b0);
    load = 1'b1; tick(1); load = 1'b0;
    expect_st("load_held", 8'd16, 10'b1111100000, 1'b0, 1'b0);
    tick(1); expect_st("idle_after", 8'd32, 10'b1111000000, 1'b0, 1'b0);
    increase = 1'b0; tick(2);

    // overflow guard
    max_period = 8'd255; init_period = 8'd128;
    load = 1'b1; tick(1); load = 1'b0;
    expect_st("ovf_load", 8'd128, 10'b1111100000, 1'b1, 1'b0);
    increase = 1'b1; tick(1); increase = 1'b0;
    expect_st("ovf_rej", 8'd128, 10'b1111100000, 1'b1, 1'b0);
    tick(2);

    // lower bound
    max_period = 8'd128; init_period = 8'd2;
    load = 1'b1; tick(1); load = 1'b0;
    decrease = 1'b1; tick(1); decrease = 1'b0;
    expect_st("min_rej", 8'd2, 10'b1111100000, 1'b0, 1'b1);
    tick(2);

    // both buttons: no step, FSM stays IDLE so a lone press steps at once
    init_period = 8'd16;
    load = 1'b1; tick(1); load = 1'b0;
    increase = 1'b1; decrease = 1'b1; tick(3);
    expect_st("both", 8'd16, 10'b1111100000, 1'b0, 1'b0);
    increase = 1'b0; tick(1);
    expect_st("dec8", 8'd8, 10'b1111110000, 1'b0, 1'b0);
    decrease = 1'b0;
    tick(2);

    if (q.size() != 0) begin
      tot_cnt++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/period_stepper.md
Name: period_stepper

Overview:
- Parametrised period register that doubles or halves in octave steps, driven by increase/decrease buttons held at level.
- Successor to the single-step period modifier. Adds:
  - hold-to-auto-repeat
  - overflow-safe bound checks
  - an LED level bar that moves only when a step is accepted
  - a square-wave tone output at the current period
- Sits between debounced pushbuttons and the audio/LED outputs.

Parameters:
- WIDTH, 24, bit width of period and bound inputs.
- LED_W, 10, LED bar width. Reset level is LED_W/2.
- HOLD_CYCLES, 25000000, cycles a button must stay held after the first step before the second step.
- REPEAT_CYCLES, 5000000, cycles between auto-repeat steps after the second step.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- init_period  input  WIDTH  period loaded after reset release or on load
- max_period  input  WIDTH  upper bound for doubling
- min_period  input  WIDTH  lower bound for halving
- load  input  1  synchronous reload request
- increase  input  1  level, button held = 1
- decrease  input  1  level, button held = 1
- period  output  WIDTH  current period
- led  output  LED_W  thermometer bar, top `lvl` bits set
- tone_out  output  1  square wave, high and low phases each `period` cycles
- at_max  output  1  next doubling would be rejected
- at_min  output  1  next halving would be rejected

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - period=0, lvl=LED_W/2 so led=upper LED_W/2 bits set (LED_W=10: 1111100000).
  - tone_out=0, tone counter=0, hold counter=0, FSM=LOAD.
- LOAD (one cycle):
  - period<=init_period, lvl<=LED_W/2, counters cleared, next IDLE.
  - init_period outside [min,max] is accepted as-is.
- load=1 in any state: same actions as LOAD on that edge, next IDLE. Highest synchronous priority.
- Step acceptance:
  - Double: accepted iff the (WIDTH+1)-bit value {period,0} <= max_period. Then period<=period<<1 and lvl<=lvl-1, saturating at 0.
  - Halve: accepted iff period>>1 >= min_period and period>>1 != 0. Then period<=period>>1 and lvl<=lvl+1, saturating at LED_W.
  - Rejected step: period and lvl unchanged.
- at_max / at_min: combinational negation of the respective acceptance test.
- Press FSM states: LOAD, IDLE, HOLD, REPEAT. A direction register records the held button.
  - IDLE, exactly one of increase/decrease high: attempt step on that edge, record direction, clear hold counter, go HOLD.
  - IDLE, both or neither high: stay IDLE, no step.
  - HOLD/REPEAT, recorded button low, or both high: go IDLE next edge, no step.
  - HOLD, counter = HOLD_CYCLES-1: attempt step, clear counter, go REPEAT. Otherwise increment counter.
  - REPEAT, counter = REPEAT_CYCLES-1: attempt step, clear counter. Otherwise increment counter.
  - Rejected attempts still restart counters; the FSM stays in HOLD/REPEAT.
- Latency: an accepted step changes period and led on the same edge at which the press is sampled.
- Tone generator:
  - Counter runs 0..period-1; tone_out toggles at period-1 and the counter returns to 0.
  - Any accepted step or load clears the counter; tone_out is not cleared.
  - period=0: tone_out forced 0, counter held at 0.
- Reset mid-operation: immediate return to reset values; a held button after release does nothing until the next IDLE sample (LOAD cycle first).

Test Plan:
All scenarios use WIDTH=8, LED_W=10, HOLD_CYCLES=4, REPEAT_CYCLES=2, min=2, max=128 unless noted.
- Reset/load, init=16 -> during reset period=0, led=1111100000. One cycle after release period=16. tone_out toggles every 16 cycles.
- increase pulsed 1 cycle at period=16 -> period=32, led=1111000000, no further step. Release then re-press -> period=64.
- increase held 10 cycles from 16:
  - steps at cycle 0 (32), cycle 4 (64), cycle 6 (128)
  - cycle 8 rejected: period stays 128, at_max=1, led=1100000000.
- Overflow guard: max=255, period=128, press increase -> 256 not representable, rejected, period=128, at_max=1.
- period=2, press decrease -> rejected, led unchanged, at_min=1. Both buttons high from IDLE -> no change, FSM stays IDLE.
- Assert reset asynchronously mid-REPEAT (between clk edges) -> outputs reach reset values before the next edge. load=1 while increase held -> period=init_period, FSM IDLE.
